// File: rtl/seg_scan_mux.sv
// rtl/seg_scan_mux.sv - three-digit 7-segment scan driver with frame-aligned double buffering
// Lamp patterns are captured into a shadow on load and promoted to the display at frame boundaries.
module seg_scan_mux #(
    parameter int         DIV       = 4,
    parameter logic [6:0] ZERO_PAT  = 7'b0111111,
    parameter logic [6:0] BLANK_PAT = 7'b0000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [6:0] ones_lamp,
    input  logic [6:0] tens_lamp,
    input  logic [6:0] hundreds_lamp,
    input  logic       blank_lz,
    output logic [6:0] seg_out,
    output logic [2:0] digit_en,
    output logic       frame_done
);
    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

    typedef enum logic [1:0] {
        ONES     = 2'd0,
        TENS     = 2'd1,
        HUNDREDS = 2'd2
    } state_t;

    state_t         idx_q, idx_d;
    logic [CW-1:0]  cnt_q;
    logic           tick, boundary;
    logic           pending_q;
    logic [6:0]     sh_o_q, sh_t_q, sh_h_q;
    logic [6:0]     dp_o_q, dp_t_q, dp_h_q;
    logic [6:0]     dp_o_d, dp_t_d, dp_h_d;
    logic           h_blank, t_blank;
    logic [6:0]     seg_d;
    logic [2:0]     en_d;

    assign tick     = (cnt_q == CW'(DIV - 1));
    assign boundary = tick && (idx_q == HUNDREDS);

    always_comb begin
        idx_d = idx_q;
        case (idx_q)
            ONES:    idx_d = TENS;
            TENS:    idx_d = HUNDREDS;
            default: idx_d = ONES;
        endcase
    end

    // A load landing on the boundary bypasses the shadow so it is not delayed a whole frame.
    always_comb begin
        dp_o_d = dp_o_q;
        dp_t_d = dp_t_q;
        dp_h_d = dp_h_q;
        if (boundary && load) begin
            dp_o_d = ones_lamp;
            dp_t_d = tens_lamp;
            dp_h_d = hundreds_lamp;
        end else if (boundary && pending_q) begin
            dp_o_d = sh_o_q;
            dp_t_d = sh_t_q;
            dp_h_d = sh_h_q;
        end
    end

    always_comb begin
        h_blank = blank_lz && (dp_h_d == ZERO_PAT);
        t_blank = h_blank && (dp_t_d == ZERO_PAT);
        seg_d   = dp_o_d;
        case (idx_d)
            TENS:     seg_d = t_blank ? BLANK_PAT : dp_t_d;
            HUNDREDS: seg_d = h_blank ? BLANK_PAT : dp_h_d;
            default:  seg_d = dp_o_d;
        endcase
        en_d = 3'b001 << idx_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q      <= '0;
            idx_q      <= ONES;
            seg_out    <= BLANK_PAT;
            digit_en   <= 3'b001;
            frame_done <= 1'b0;
            pending_q  <= 1'b0;
            sh_o_q     <= BLANK_PAT;
            sh_t_q     <= BLANK_PAT;
            sh_h_q     <= BLANK_PAT;
            dp_o_q     <= BLANK_PAT;
            dp_t_q     <= BLANK_PAT;
            dp_h_q     <= BLANK_PAT;
        end else begin
            cnt_q      <= tick ? '0 : cnt_q + CW'(1);
            frame_done <= boundary;
            if (tick) begin
                idx_q    <= idx_d;
                seg_out  <= seg_d;
                digit_en <= en_d;
            end
            if (load) begin
                sh_o_q <= ones_lamp;
                sh_t_q <= tens_lamp;
                sh_h_q <= hundreds_lamp;
            end
            if (boundary)
                pending_q <= 1'b0;
            else if (load)
                pending_q <= 1'b1;
            dp_o_q <= dp_o_d;
            dp_t_q <= dp_t_d;
            dp_h_q <= dp_h_d;
        end
    end
endmodule

// File: tb/tb_seg_scan_mux.sv
// tb/tb_seg_scan_mux.sv - randomized self-checking bench for seg_scan_mux
// Expected outputs come from a time-arithmetic model of frames and dwell slots.
module tb_seg_scan_mux;
    localparam int         DV    = 4;
    localparam logic [6:0] ZERO  = 7'b0111111;
    localparam logic [6:0] BLANK = 7'b0000000;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       load = 1'b0;
    logic [6:0] ones_lamp = '0, tens_lamp = '0, hundreds_lamp = '0;
    logic       blank_lz = 1'b0;
    logic [6:0] seg4, seg1;
    logic [2:0] en4, en1;
    logic       fd4, fd1;

    int n_checks = 0;
    int n_fail   = 0;

    // model state: edges since reset release, shadow, display, pending
    int         m_t;
    logic [6:0] m_sh [3];
    logic [6:0] m_dp [3];
    logic       m_pend;
    logic [6:0] exp_seg;
    logic [2:0] exp_en;
    logic       exp_fd;

    always #5 clk = ~clk;

    seg_scan_mux #(.DIV(DV)) u_dut4 (
        .clk(clk), .rst(rst), .load(load), .ones_lamp(ones_lamp), .tens_lamp(tens_lamp),
        .hundreds_lamp(hundreds_lamp), .blank_lz(blank_lz),
        .seg_out(seg4), .digit_en(en4), .frame_done(fd4)
    );

    seg_scan_mux #(.DIV(1)) u_dut1 (
        .clk(clk), .rst(rst), .load(load), .ones_lamp(ones_lamp), .tens_lamp(tens_lamp),
        .hundreds_lamp(hundreds_lamp), .blank_lz(blank_lz),
        .seg_out(seg1), .digit_en(en1), .frame_done(fd1)
    );

    task automatic step(input logic r, input logic ld, input logic [6:0] h, input logic [6:0] t,
                        input logic [6:0] o, input logic bl);
        int  nt, d;
        logic bnd;
        rst = r; load = ld; hundreds_lamp = h; tens_lamp = t; ones_lamp = o; blank_lz = bl;
        if (r) begin
            m_t = 0; m_pend = 1'b0;
            for (int i = 0; i < 3; i++) begin m_sh[i] = BLANK; m_dp[i] = BLANK; end
            exp_seg = BLANK; exp_en = 3'b001; exp_fd = 1'b0;
        end else begin
            nt  = m_t + 1;
            bnd = (nt % (3 * DV)) == 0;
            if (ld && bnd) begin
                m_dp[0] = o; m_dp[1] = t; m_dp[2] = h; m_pend = 1'b0;
            end else if (bnd && m_pend) begin
                m_dp = m_sh; m_pend = 1'b0;
            end
            if (ld && !bnd) begin
                m_sh[0] = o; m_sh[1] = t; m_sh[2] = h; m_pend = 1'b1;
            end
            if ((nt % DV) == 0) begin
                d      = (nt / DV) % 3;
                exp_en = 3'b001 << d;
                if (d == 0)
                    exp_seg = m_dp[0];
                else if (d == 1)
                    exp_seg = (bl && m_dp[2] == ZERO && m_dp[1] == ZERO) ? BLANK : m_dp[1];
                else
                    exp_seg = (bl && m_dp[2] == ZERO) ? BLANK : m_dp[2];
            end
            exp_fd = bnd;
            m_t    = nt;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        step(1'b1, 1'b0, '0, '0, '0, 1'b0);
        step(1'b1, 1'b0, '0, '0, '0, 1'b0);
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if ({seg4, en4, fd4} !== {BLANK, 3'b001, 1'b0}) begin
            n_fail++; $display("FAIL reset_state got %b/%b/%b exp %b/001/0", seg4, en4, fd4, BLANK);
        end
        for (int k = 1; k <= 13; k++) begin
            step(1'b0, 1'b0, '0, '0, '0, 1'b0);
            n_checks++;
            if ({seg4, en4, fd4} !== {exp_seg, exp_en, exp_fd}) begin
                n_fail++; $display("FAIL reset_seq k=%0d got %b/%b/%b exp %b/%b/%b", k, seg4, en4, fd4, exp_seg, exp_en, exp_fd);
            end
            n_checks++;
            if (en4 !== ((k < 4 || k >= 12) ? 3'b001 : (k < 8 ? 3'b010 : 3'b100)) || fd4 !== (k == 12)) begin
                n_fail++; $display("FAIL reset_rotation k=%0d got en=%b fd=%b", k, en4, fd4);
            end
        end
    endtask

    task automatic test_commit();
        do_reset();
        for (int k = 1; k <= 24; k++) begin
            step(1'b0, k == 2, ZERO, 7'b1111111, 7'b0000110, 1'b0);
            n_checks++;
            if ({seg4, en4, fd4} !== {exp_seg, exp_en, exp_fd}) begin
                n_fail++; $display("FAIL commit k=%0d got %b/%b/%b exp %b/%b/%b", k, seg4, en4, fd4, exp_seg, exp_en, exp_fd);
            end
            if (k == 11 || k == 12 || k == 16 || k == 20) begin
                n_checks++;
                if (seg4 !== (k == 11 ? BLANK : k == 12 ? 7'b0000110 : k == 16 ? 7'b1111111 : ZERO)) begin
                    n_fail++; $display("FAIL commit_value k=%0d got %b", k, seg4);
                end
            end
        end
    endtask

    task automatic test_blanking();
        do_reset();
        for (int k = 1; k <= 48; k++) begin
            if (k < 26)
                step(1'b0, k == 2, ZERO, 7'b1111111, 7'b0000110, 1'b1);
            else
                step(1'b0, k == 26, ZERO, ZERO, ZERO, 1'b1);
            n_checks++;
            if ({seg4, en4, fd4} !== {exp_seg, exp_en, exp_fd}) begin
                n_fail++; $display("FAIL blank k=%0d got %b/%b/%b exp %b/%b/%b", k, seg4, en4, fd4, exp_seg, exp_en, exp_fd);
            end
            if (k == 16 || k == 20 || k == 36 || k == 40 || k == 44) begin
                n_checks++;
                if (seg4 !== (k == 16 ? 7'b1111111 : k == 36 ? ZERO : BLANK)) begin
                    n_fail++; $display("FAIL blank_value k=%0d got %b", k, seg4);
                end
            end
        end
    endtask

    task automatic test_latest_wins();
        logic [6:0] b [3];
        do_reset();
        for (int i = 0; i < 3; i++) b[i] = 7'($urandom);
        for (int k = 1; k <= 24; k++) begin
            if (k == 2)
                step(1'b0, 1'b1, b[2] ^ 7'h01, b[1] ^ 7'h01, b[0] ^ 7'h01, 1'b0);
            else
                step(1'b0, k == 6, b[2], b[1], b[0], 1'b0);
            n_checks++;
            if ({seg4, en4, fd4} !== {exp_seg, exp_en, exp_fd}) begin
                n_fail++; $display("FAIL latest k=%0d got %b/%b/%b exp %b/%b/%b", k, seg4, en4, fd4, exp_seg, exp_en, exp_fd);
            end
            if (k >= 12) begin
                n_checks++;
                if (seg4 !== b[((k - 12) / DV) % 3]) begin
                    n_fail++; $display("FAIL latest_value k=%0d got %b exp %b", k, seg4, b[((k - 12) / DV) % 3]);
                end
            end
        end
    endtask

    task automatic test_boundary_bypass();
        logic [6:0] x;
        do_reset();
        x = 7'($urandom) | 7'h40;
        for (int k = 1; k <= 26; k++) begin
            if (k == 5)
                step(1'b0, 1'b1, 7'h11, 7'h22, 7'h33, 1'b0);
            else
                step(1'b0, k == 12, x, x ^ 7'h05, x ^ 7'h0a, 1'b0);
            n_checks++;
            if ({seg4, en4, fd4} !== {exp_seg, exp_en, exp_fd}) begin
                n_fail++; $display("FAIL bypass k=%0d got %b/%b/%b exp %b/%b/%b", k, seg4, en4, fd4, exp_seg, exp_en, exp_fd);
            end
            if (k == 12) begin
                n_checks++;
                if (seg4 !== (x ^ 7'h0a) || u_dut4.pending_q !== 1'b0) begin
                    n_fail++; $display("FAIL bypass_edge got seg=%b pend=%b exp seg=%b pend=0", seg4, u_dut4.pending_q, x ^ 7'h0a);
                end
            end
        end
    endtask

    task automatic test_div1();
        do_reset();
        for (int k = 1; k <= 30; k++) begin
            step(1'b0, 1'b0, '0, '0, '0, 1'b0);
            n_checks++;
            if (en1 !== (3'b001 << (k % 3)) || fd1 !== ((k % 3) == 0)) begin
                n_fail++; $display("FAIL div1 k=%0d got en=%b fd=%b exp en=%b fd=%b", k, en1, fd1, 3'b001 << (k % 3), (k % 3) == 0);
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        do_reset();
        for (int k = 1; k <= 16; k++) begin
            step(1'b0, k == 14, 7'h5a, 7'h3c, 7'h66, 1'b0);
        end
        step(1'b1, 1'b1, 7'h5a, 7'h3c, 7'h66, 1'b0);
        n_checks++;
        if ({seg4, en4, fd4} !== {BLANK, 3'b001, 1'b0}) begin
            n_fail++; $display("FAIL midreset_state got %b/%b/%b exp %b/001/0", seg4, en4, fd4, BLANK);
        end
        for (int k = 1; k <= 24; k++) begin
            step(1'b0, 1'b0, '0, '0, '0, 1'b0);
            n_checks++;
            if ({seg4, en4, fd4} !== {exp_seg, exp_en, exp_fd} || seg4 !== BLANK) begin
                n_fail++; $display("FAIL midreset k=%0d got %b/%b/%b exp %b/%b/%b", k, seg4, en4, fd4, exp_seg, exp_en, exp_fd);
            end
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int k = 1; k <= 300; k++) begin
            step(1'b0, $urandom_range(0, 7) == 0,
                 ($urandom_range(0, 1) == 0) ? ZERO : 7'($urandom),
                 ($urandom_range(0, 1) == 0) ? ZERO : 7'($urandom),
                 7'($urandom), $urandom_range(0, 1) == 1);
            n_checks++;
            if ({seg4, en4, fd4} !== {exp_seg, exp_en, exp_fd}) begin
                n_fail++; $display("FAIL random k=%0d got %b/%b/%b exp %b/%b/%b", k, seg4, en4, fd4, exp_seg, exp_en, exp_fd);
            end
        end
    endtask

    initial begin
        test_reset();
        test_commit();
        test_blanking();
        test_latest_wins();
        test_boundary_bypass();
        test_div1();
        test_reset_mid_frame();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
